// File: rtl/nanorv32_uart_tx_pkg.sv
// Shared definitions for the nanorv32 UART transmitter: register map, STATUS layout,
// FSM state encoding and the DIV clamp helper.
package nanorv32_uart_tx_pkg;

  localparam logic [1:0] UartRegData   = 2'd0;
  localparam logic [1:0] UartRegStatus = 2'd1;
  localparam logic [1:0] UartRegDiv    = 2'd2;
  localparam logic [1:0] UartRegRsvd   = 2'd3;

  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusBusyBit  = 2;
  localparam int unsigned StatusCountLsb = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  // A bit period shorter than two clocks cannot be sampled reliably.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < 16'd2) ? 16'd2 : value;
  endfunction

endpackage

// File: rtl/nanorv32_sync_fifo.sv
// Single-clock FIFO with combinational read data; count is one bit wider than the
// pointers so full and empty are distinguishable.
module nanorv32_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nanorv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the nanorv32 native bus: address decode,
// DATA/STATUS/DIV registers, TX FIFO, baud counter and serializer FSM.
module nanorv32_uart_tx
  import nanorv32_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        txd,
  output logic        irq_txe
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [AW:0] fifo_count;

  nanorv32_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (mem_wdata[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // ---------------- bus decode and registers ----------------
  logic        mem_ready_q;
  logic [31:0] mem_rdata_q, rdata_d;
  logic [15:0] div_q, div_d, div_merged;
  logic        hit, is_write, push_req, accept, div_wr;
  logic [1:0]  reg_sel;
  uart_state_e state_q, state_d;
  logic        unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  // Qualifying with !mem_ready keeps the ack from firing on consecutive cycles.
  assign hit      = mem_valid && !mem_ready_q && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = mem_addr[3:2];
  assign is_write = |mem_wstrb;
  assign push_req = hit && (reg_sel == UartRegData) && mem_wstrb[0];
  assign fifo_push = push_req && !fifo_full;
  assign accept   = hit && !(push_req && fifo_full);
  assign div_wr   = hit && (reg_sel == UartRegDiv) && is_write;

  always_comb begin
    div_merged = div_q;
    if (mem_wstrb[0]) div_merged[7:0]  = mem_wdata[7:0];
    if (mem_wstrb[1]) div_merged[15:8] = mem_wdata[15:8];
    div_d = div_wr ? clamp_div(div_merged) : div_q;
  end

  always_comb begin
    rdata_d = '0;
    if (!is_write) begin
      unique case (reg_sel)
        UartRegStatus: begin
          rdata_d[StatusEmptyBit]        = fifo_empty;
          rdata_d[StatusFullBit]         = fifo_full;
          rdata_d[StatusBusyBit]         = (state_q != StIdle);
          rdata_d[StatusCountLsb +: 8]   = 8'(fifo_count);
        end
        UartRegDiv: rdata_d = {16'h0000, div_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      div_q       <= DEFAULT_DIV;
    end else begin
      mem_ready_q <= accept;
      mem_rdata_q <= accept ? rdata_d : '0;
      div_q       <= div_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;

  // ---------------- serializer ----------------
  logic [15:0] baud_q, div_lat_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tick, start_frame;

  assign tick = (baud_q == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d     = StStart;
          start_frame = 1'b1;
        end
      end
      StStart: if (tick) state_d = StData;
      StData:  if (tick && bit_q == 3'd7) state_d = StStop;
      StStop: begin
        if (tick) begin
          if (!fifo_empty) begin
            state_d     = StStart;
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_pop = start_frame;
    irq_txe  = fifo_empty && (state_q == StIdle);
    unique case (state_q)
      StStart: txd = 1'b0;
      StData:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  // DIV is latched per frame so a mid-frame write only affects the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q    <= '0;
      div_lat_q <= DEFAULT_DIV;
      bit_q     <= '0;
      shift_q   <= '0;
    end else if (start_frame) begin
      shift_q   <= fifo_dout;
      div_lat_q <= div_q;
      baud_q    <= div_q - 16'd1;
      bit_q     <= '0;
    end else if (state_q != StIdle) begin
      if (tick) begin
        baud_q <= div_lat_q - 16'd1;
        if (state_q == StData) begin
          shift_q <= {1'b0, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
        end
      end else begin
        baud_q <= baud_q - 16'd1;
      end
    end
  end

endmodule
